cpu_exec_stage: RTL

Execute-stage wrapper that sits between decode and writeback. It accepts decoded RV32I micro-ops on a valid/ready handshake and generates the 4-bit ALU control code. It drives operands into one cpu_alu instance and consumes that instance's result and flags to resolve branches and jumps. Results are registered into a 2-entry output buffer (main plus skid) with a valid/ready handshake, so backpressure never drops or duplicates an op.

---
 rtl/cpu_exec_pkg.sv | 48 ++++
 rtl/cpu_alu.sv | 47 ++++
 rtl/cpu_exec_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cpu_exec_pkg.sv
// Shared definitions for the RV32I execute stage: ALU control codes, op classes,
// branch funct3 encodings and the registered result entry.
package cpu_exec_pkg;

  localparam int EXEC_XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef enum logic [2:0] {
    CL_OP     = 3'd0,
    CL_OP_IMM = 3'd1,
    CL_BRANCH = 3'd2,
    CL_LUI    = 3'd3,
    CL_AUIPC  = 3'd4,
    CL_JAL    = 3'd5,
    CL_JALR   = 3'd6
  } op_class_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [4:0]           rd;
    logic [EXEC_XLEN-1:0] result;
    logic                 redirect;
    logic [EXEC_XLEN-1:0] target;
    logic                 illegal;
  } exec_entry_t;

  function automatic logic [EXEC_XLEN-1:0] align_target(input logic [EXEC_XLEN-1:0] a,
                                                        input logic en);
    align_target = {a[EXEC_XLEN-1:1], a[0] & ~en};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational RV32I ALU with comparison flags used for branch resolution.
module cpu_alu
  import cpu_exec_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_BITS = $clog2(XLEN)
) (
  input  logic [3:0]      i_ctrl,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero,
  output logic            o_less_than,
  output logic            o_unsigned_less_than
);

  logic signed [XLEN-1:0] w_a_s;
  logic signed [XLEN-1:0] w_b_s;
  logic [SHIFT_BITS-1:0]  w_shamt;

  assign w_a_s   = i_a;
  assign w_b_s   = i_b;
  assign w_shamt = i_b[SHIFT_BITS-1:0];

  assign o_less_than          = (w_a_s < w_b_s);
  assign o_unsigned_less_than = (i_a < i_b);

  always_comb begin
    o_result = '0;
    case (i_ctrl)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SLL:  o_result = i_a << w_shamt;
      ALU_SRL:  o_result = i_a >> w_shamt;
      ALU_SRA:  o_result = w_a_s >>> w_shamt;
      ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, o_less_than};
      ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, o_unsigned_less_than};
      default:  o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/cpu_exec_stage.sv
// Execute stage: decodes ALU control, resolves branches/jumps and buffers
// results in a main+skid pair so backpressure never drops or duplicates an op.
module cpu_exec_stage
  import cpu_exec_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit RESET_PC_ALIGN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_class,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_result,
  output logic            out_redirect,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam int SHIFT_BITS = $clog2(XLEN);

  op_class_t   w_class;
  logic [3:0]  w_alu_ctrl;
  logic [XLEN-1:0] w_alu_b;
  logic [XLEN-1:0] w_alu_result;
  logic        w_zero;
  logic        w_lt;
  logic        w_ult;
  logic [XLEN-1:0] w_pc_imm;
  logic [XLEN-1:0] w_pc_4;
  logic        w_taken;
  logic        w_illegal;
  exec_entry_t w_entry_p0;

  exec_entry_t r_main_p1;
  exec_entry_t r_skid_p1;
  logic        r_main_vld_p1;
  logic        r_skid_vld_p1;

  logic        w_accept;
  logic        w_drain;

  assign w_class  = op_class_t'(in_class);
  assign w_alu_b  = (w_class == CL_OP || w_class == CL_BRANCH) ? in_rs2 : in_imm;
  assign w_pc_imm = in_pc + in_imm;
  assign w_pc_4   = in_pc + XLEN'(4);

  always_comb begin
    w_alu_ctrl = ALU_ADD;
    case (in_funct3)
      3'b000:  w_alu_ctrl = (w_class == CL_OP && in_funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_ctrl = ALU_SLL;
      3'b010:  w_alu_ctrl = ALU_SLT;
      3'b011:  w_alu_ctrl = ALU_SLTU;
      3'b100:  w_alu_ctrl = ALU_XOR;
      3'b101:  w_alu_ctrl = in_funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_ctrl = ALU_OR;
      default: w_alu_ctrl = ALU_AND;
    endcase
    // Branches compare via subtraction; other non-ALU classes reuse ADD for the JALR target.
    if (w_class == CL_BRANCH) w_alu_ctrl = ALU_SUB;
    else if (w_class != CL_OP && w_class != CL_OP_IMM) w_alu_ctrl = ALU_ADD;
  end

  cpu_alu #(
    .XLEN       (XLEN),
    .SHIFT_BITS (SHIFT_BITS)
  ) u_alu (
    .i_ctrl               (w_alu_ctrl),
    .i_a                  (in_rs1),
    .i_b                  (w_alu_b),
    .o_result             (w_alu_result),
    .o_zero               (w_zero),
    .o_less_than          (w_lt),
    .o_unsigned_less_than (w_ult)
  );

  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    w_entry_p0 = '{rd: in_rd, result: w_alu_result, redirect: 1'b0, target: '0, illegal: 1'b0};
    case (w_class)
      CL_OP:     w_illegal = in_funct7_5 && (in_funct3 != 3'b000) && (in_funct3 != 3'b101);
      CL_OP_IMM: w_illegal = in_funct7_5 && (in_funct3 == 3'b001);
      CL_BRANCH: begin
        case (in_funct3)
          F3_BEQ:  w_taken = w_zero;
          F3_BNE:  w_taken = !w_zero;
          F3_BLT:  w_taken = w_lt;
          F3_BGE:  w_taken = !w_lt;
          F3_BLTU: w_taken = w_ult;
          F3_BGEU: w_taken = !w_ult;
          default: w_illegal = 1'b1;
        endcase
        w_entry_p0.rd       = '0;
        w_entry_p0.redirect = w_taken;
        w_entry_p0.target   = w_pc_imm;
      end
      CL_LUI:    w_entry_p0.result = in_imm;
      CL_AUIPC:  w_entry_p0.result = w_pc_imm;
      CL_JAL: begin
        w_entry_p0.result   = w_pc_4;
        w_entry_p0.redirect = 1'b1;
        w_entry_p0.target   = w_pc_imm;
      end
      CL_JALR: begin
        w_entry_p0.result   = w_pc_4;
        w_entry_p0.redirect = 1'b1;
        w_entry_p0.target   = align_target(w_alu_result, RESET_PC_ALIGN);
      end
      default:   w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_entry_p0.rd       = '0;
      w_entry_p0.redirect = 1'b0;
    end
    w_entry_p0.illegal = w_illegal;
  end

  // Stage boundary: main + skid result buffer
  assign in_ready = rst_n && !r_skid_vld_p1;
  assign w_accept = in_valid && in_ready;
  assign w_drain  = r_main_vld_p1 && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main_vld_p1 <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
      r_main_p1     <= '0;
      r_skid_p1     <= '0;
    end else if (flush) begin
      r_main_vld_p1 <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
    end else if (w_drain || !r_main_vld_p1) begin
      // A valid skid implies in_ready was low, so no accept competes with the refill.
      if (r_skid_vld_p1) begin
        r_main_p1     <= r_skid_p1;
        r_main_vld_p1 <= 1'b1;
        r_skid_vld_p1 <= 1'b0;
      end else if (w_accept) begin
        r_main_p1     <= w_entry_p0;
        r_main_vld_p1 <= 1'b1;
      end else begin
        r_main_vld_p1 <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_p1     <= w_entry_p0;
      r_skid_vld_p1 <= 1'b1;
    end
  end

  assign out_valid    = r_main_vld_p1;
  assign out_rd       = r_main_p1.rd;
  assign out_result   = r_main_p1.result;
  assign out_redirect = r_main_p1.redirect;
  assign out_target   = r_main_p1.target;
  assign out_illegal  = r_main_p1.illegal;

endmodule
